// File: rtl/snap_pkg.sv
// Shared types and widths for the frame-synchronous snapshot commit controller.
package snap_pkg;

  localparam int REZ_W   = 32;
  localparam int MARK_W  = 8;
  localparam int TIM_W   = 16;
  localparam int BLINK_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [REZ_W-1:0]  rez1;
    logic [REZ_W-1:0]  rez2;
    logic [MARK_W-1:0] mark;
  } a_data_t;

  typedef struct packed {
    logic [TIM_W-1:0] freq;
    logic [TIM_W-1:0] elapsed;
  } b_data_t;

  // True on the cycle vs enters its active level.
  function automatic logic sync_edge(input logic vs, input logic vs_prev, input logic pol);
    return (vs == pol) && (vs_prev != pol);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer favours A out of reset and moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  // ptr_q == 0 favours A, ptr_q == 1 favours B.
  logic ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/snap_commit_ctrl.sv
// Shadows updates from the test engine (A) and timing source (B) and commits them atomically at vsync.
// Optional build macro SNAP_BLINK_EN adds a 32-frame on/off blink of the committed marker.
module snap_commit_ctrl
  import snap_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs,
  input  logic              a_req,
  output logic              a_ack,
  input  logic [REZ_W-1:0]  a_rez1,
  input  logic [REZ_W-1:0]  a_rez2,
  input  logic [MARK_W-1:0] a_mark,
  input  logic              b_req,
  output logic              b_ack,
  input  logic [TIM_W-1:0]  b_freq,
  input  logic [TIM_W-1:0]  b_elapsed,
  output logic [REZ_W-1:0]  rez1,
  output logic [REZ_W-1:0]  rez2,
  output logic [MARK_W-1:0] mark,
  output logic [TIM_W-1:0]  freq,
  output logic [TIM_W-1:0]  elapsed,
  output logic [1:0]        pending,
  output logic              frame_tick
);

  state_e     state_q, state_d;
  logic       vs_prev_q;
  logic       edge_w;
  logic       commit;
  logic       arb_en;
  logic [1:0] req_elig;
  logic [1:0] gnt;
  logic       arb_ptr;

  logic [1:0] ack_q, ack_d;
  logic [1:0] dirty_q, dirty_d;
  logic       frame_tick_q, frame_tick_d;
  a_data_t    a_shadow_q, a_shadow_d, a_out_q, a_out_d;
  b_data_t    b_shadow_q, b_shadow_d, b_out_q, b_out_d;

  assign edge_w = sync_edge(vs, vs_prev_q, VS_POL);

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (edge_w) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acks are registered, so a grant decided now is visible next cycle. Blocking grants
  // whenever the next state is COMMIT keeps acks out of the COMMIT cycle, while a request
  // seen during COMMIT is acked in the IDLE cycle that follows.
  assign arb_en = (state_d == IDLE);

  // A port whose ack is showing has not yet dropped req; it becomes eligible again next cycle.
  assign req_elig = {b_req, a_req} & ~ack_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (arb_en),
    .req_i (req_elig),
    .gnt_o (gnt),
    .ptr_o (arb_ptr)
  );

  always_comb begin
    ack_d        = gnt;
    frame_tick_d = commit;
    dirty_d      = dirty_q;
    a_shadow_d   = a_shadow_q;
    b_shadow_d   = b_shadow_q;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;

    if (commit) begin
      if (dirty_q[0]) a_out_d = a_shadow_q;
      if (dirty_q[1]) b_out_d = b_shadow_q;
      dirty_d = 2'b00;
    end

    // A grant landing on the commit edge refills the shadow after the copy, so it stays pending.
    if (gnt[0]) begin
      a_shadow_d = '{rez1: a_rez1, rez2: a_rez2, mark: a_mark};
      dirty_d[0] = 1'b1;
    end
    if (gnt[1]) begin
      b_shadow_d = '{freq: b_freq, elapsed: b_elapsed};
      dirty_d[1] = 1'b1;
    end
  end

  // NOTE: shadows and outputs are plain registers, not RAM, so they take a defined reset value
  // and an aborted commit leaves nothing half-written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      vs_prev_q    <= VS_POL;
      ack_q        <= 2'b00;
      dirty_q      <= 2'b00;
      frame_tick_q <= 1'b0;
      a_shadow_q   <= '0;
      b_shadow_q   <= '0;
      a_out_q      <= '0;
      b_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs;
      ack_q        <= ack_d;
      dirty_q      <= dirty_d;
      frame_tick_q <= frame_tick_d;
      a_shadow_q   <= a_shadow_d;
      b_shadow_q   <= b_shadow_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
    end
  end

`ifdef SNAP_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  assign blink_cnt_d = commit ? blink_cnt_q + 1'b1 : blink_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign mark = blink_cnt_q[BLINK_W-1] ? '0 : a_out_q.mark;
`else
  assign mark = a_out_q.mark;
`endif

  assign a_ack      = ack_q[0];
  assign b_ack      = ack_q[1];
  assign rez1       = a_out_q.rez1;
  assign rez2       = a_out_q.rez2;
  assign freq       = b_out_q.freq;
  assign elapsed    = b_out_q.elapsed;
  assign pending    = dirty_q;
  assign frame_tick = frame_tick_q;

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(a_ack && b_ack));
  no_ack_in_commit: assert property (@(posedge clk) disable iff (reset)
    (state_q == COMMIT) |-> (ack_q == 2'b00));
  ptr_follows_grant: assert property (@(posedge clk) disable iff (reset)
    (ack_q != 2'b00) |-> (arb_ptr == ack_q[0]));

endmodule

// File: tb/tb_snap_commit_ctrl.sv
// Self-checking bench for snap_commit_ctrl: scoreboard of committed snapshots plus a vector table.
module tb_snap_commit_ctrl;
  import snap_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_rez1 = '0, a_rez2 = '0;
  logic [7:0]  a_mark = '0;
  logic [15:0] b_freq = '0, b_elapsed = '0;
  logic        a_ack, b_ack, frame_tick;
  logic [31:0] rez1, rez2;
  logic [7:0]  mark;
  logic [15:0] freq, elapsed;
  logic [1:0]  pending;

  snap_commit_ctrl #(.VS_POL(1'b1)) dut (
    .clk(clk), .reset(reset), .vs(vs),
    .a_req(a_req), .a_ack(a_ack), .a_rez1(a_rez1), .a_rez2(a_rez2), .a_mark(a_mark),
    .b_req(b_req), .b_ack(b_ack), .b_freq(b_freq), .b_elapsed(b_elapsed),
    .rez1(rez1), .rez2(rez2), .mark(mark), .freq(freq), .elapsed(elapsed),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rez1;
    logic [31:0] rez2;
    logic [7:0]  mark;
    logic [15:0] freq;
    logic [15:0] elapsed;
  } snap_t;

  typedef struct {
    bit          do_a;
    bit          do_b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [7:0]  mk;
    logic [15:0] fq;
    logic [15:0] el;
    snap_t       exp;
  } vec_t;

  snap_t model;
  snap_t exp_q[$];
  vec_t  vecs[5];
  int    n_cmp = 0;
  int    n_err = 0;
  int    lat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic snap_t actual();
    return snap_t'({rez1, rez2, mark, freq, elapsed});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic [31:0] r1, input logic [31:0] r2, input logic [7:0] mk,
                       output int latency);
    a_rez1 = r1; a_rez2 = r2; a_mark = mk; a_req = 1'b1;
    latency = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (a_ack) begin
        latency = i;
        break;
      end
    end
    a_req = 1'b0;
    check("a_ack_seen", a_ack, 1'b1);
    model.rez1 = r1; model.rez2 = r2; model.mark = mk;
  endtask

  task automatic req_b(input logic [15:0] fq, input logic [15:0] el, output int latency);
    b_freq = fq; b_elapsed = el; b_req = 1'b1;
    latency = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (b_ack) begin
        latency = i;
        break;
      end
    end
    b_req = 1'b0;
    check("b_ack_seen", b_ack, 1'b1);
    model.freq = fq; model.elapsed = el;
  endtask

  task automatic frame(input snap_t exp);
    exp_q.push_back(exp);
    vs = 1'b1;
    repeat (4) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model = '0;
  endtask

  always @(negedge clk) begin
    if (!reset && frame_tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_tick", frame_tick, 1'b0);
      end else begin
        check("commit_snapshot", actual(), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{do_a: 1, do_b: 0, r1: 32'h1111_1111, r2: 32'h2222_2222, mk: 8'h5A, fq: 16'h0, el: 16'h0,
                exp: {32'h1111_1111, 32'h2222_2222, 8'h5A, 16'h0000, 16'h0000}};
    vecs[1] = '{do_a: 0, do_b: 1, r1: 32'h0, r2: 32'h0, mk: 8'h0, fq: 16'hABCD, el: 16'h0010,
                exp: {32'h1111_1111, 32'h2222_2222, 8'h5A, 16'hABCD, 16'h0010}};
    vecs[2] = '{do_a: 1, do_b: 1, r1: 32'hDEAD_BEEF, r2: 32'h0, mk: 8'hFF, fq: 16'h0001, el: 16'hFFFF,
                exp: {32'hDEAD_BEEF, 32'h0000_0000, 8'hFF, 16'h0001, 16'hFFFF}};
    vecs[3] = '{do_a: 0, do_b: 0, r1: 32'h0, r2: 32'h0, mk: 8'h0, fq: 16'h0, el: 16'h0,
                exp: {32'hDEAD_BEEF, 32'h0000_0000, 8'hFF, 16'h0001, 16'hFFFF}};
    vecs[4] = '{do_a: 1, do_b: 0, r1: 32'hFFFF_FFFF, r2: 32'hFFFF_FFFF, mk: 8'h00, fq: 16'h0, el: 16'h0,
                exp: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 16'h0001, 16'hFFFF}};
    model = '0;

    // Reset released with vs already high: no commit, everything zero.
    vs = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_outputs", actual(), '0);
    check("reset_pending", pending, 2'b00);
    check("reset_acks", {b_ack, a_ack}, 2'b00);
    check("reset_frame_tick", frame_tick, 1'b0);
    repeat (5) tick();
    check("vs_high_no_commit", actual(), '0);
    vs = 1'b0;
    repeat (2) tick();

    // Single A update and exact commit timing.
    req_a(32'h0000_00A5, 32'h0, 8'h0, lat);
    check("a_ack_latency", lat, 1);
    check("pending_after_a", pending, 2'b01);
    exp_q.push_back(model);
    vs = 1'b1;
    tick();
    check("pre_commit_rez1", rez1, 32'h0);
    check("pre_commit_tick", frame_tick, 1'b0);
    tick();
    check("commit_rez1", rez1, 32'h0000_00A5);
    check("commit_tick", frame_tick, 1'b1);
    check("commit_pending", pending, 2'b00);
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();

    // Both requesters held: acks alternate A, B, A, B.
    do_reset();
    a_rez1 = 32'hCAFE_0001; a_rez2 = 32'hCAFE_0002; a_mark = 8'h3C;
    b_freq = 16'h0BAD; b_elapsed = 16'h0EEF;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_alternate", {b_ack, a_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) tick();
    model = {32'hCAFE_0001, 32'hCAFE_0002, 8'h3C, 16'h0BAD, 16'h0EEF};
    frame(model);

    // Two B updates before a sync: latest wins, A untouched.
    req_b(16'h1234, 16'h0042, lat);
    req_b(16'h5678, 16'h0043, lat);
    frame(model);
    check("freq_latest", freq, 16'h5678);
    check("rez1_kept", rez1, 32'hCAFE_0001);

    // Request raised in the COMMIT cycle.
    exp_q.push_back(model);
    vs = 1'b1;
    tick();
    a_rez1 = 32'h7777_7777; a_rez2 = 32'h8888_8888; a_mark = 8'hA1; a_req = 1'b1;
    @(negedge clk);
    check("no_ack_in_commit", a_ack, 1'b0);
    tick();
    check("ack_after_commit", a_ack, 1'b1);
    check("pending_after_commit_req", pending, 2'b01);
    check("rez1_not_yet", rez1, 32'hCAFE_0001);
    a_req = 1'b0;
    model.rez1 = 32'h7777_7777; model.rez2 = 32'h8888_8888; model.mark = 8'hA1;
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();
    frame(model);

    // Table-driven vectors from a clean reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_a) req_a(vecs[i].r1, vecs[i].r2, vecs[i].mk, lat);
      if (vecs[i].do_b) req_b(vecs[i].fq, vecs[i].el, lat);
      check("vec_pending", pending, {vecs[i].do_b, vecs[i].do_a});
      frame(vecs[i].exp);
      check("vec_outputs", actual(), vecs[i].exp);
    end

    // Reset asserted in the middle of COMMIT.
    req_a(32'h1357_9BDF, 32'h2468_ACE0, 8'h11, lat);
    vs = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("abort_outputs", actual(), '0);
    check("abort_pending", pending, 2'b00);
    check("abort_tick", frame_tick, 1'b0);
    tick();
    reset = 1'b0;
    model = '0;
    repeat (4) tick();
    check("abort_after_release", actual(), '0);
    check("abort_after_release_tick", frame_tick, 1'b0);
    vs = 1'b0;
    repeat (2) tick();

`ifdef SNAP_BLINK_EN
    begin
      snap_t exp;
      do_reset();
      req_a(32'h1, 32'h2, 8'h80, lat);
      for (int k = 1; k <= 33; k++) begin
        exp = model;
        exp.mark = ((k % 32) >= 16) ? 8'h00 : 8'h80;
        frame(exp);
      end
    end
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
